// File: rtl/mmio_uart_tx_if.sv
// Processor data-bus view of the memory-mapped UART transmitter.
// Latency: decode and read data are combinational; stores land on the rising clk edge.
// Backpressure: none on the bus; the device drops stores to a full queue and flags it.
interface mmio_uart_tx_if;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        Hit;

   // CPU memory stage drives the request and consumes read data / decode
   modport master (
      output Address, WriteData, MemWrite, MemRead,
      input  ReadData, Hit
   );

   // UART device decodes the request and returns read data / decode
   modport slave (
      input  Address, WriteData, MemWrite, MemRead,
      output ReadData, Hit
   );
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA store queues a byte, STATUS load polls state.
// Latency: a byte stored into an empty queue with the line idle starts its start bit 1 cycle later.
// Backpressure: none; a store to a full queue (with no pop that cycle) is dropped and sets sticky overflow.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0000,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 4
) (
   input  logic           clk,
   input  logic           reset,
   mmio_uart_tx_if.slave  bus,
   output logic           Tx,
   output logic           TxBusy
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [PW:0]   FULL_CNT  = (PW+1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nxt;
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   logic          overflow;
   logic [7:0]    shift;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;

   logic hit_data, hit_stat, full, empty;
   logic push_req, push_ok, pop, clr_ovf, bit_done;
   logic unused_wdata;

   assign hit_data = (bus.Address == BASE_ADDR);
   assign hit_stat = (bus.Address == BASE_ADDR + 32'd4);
   assign bus.Hit  = hit_data | hit_stat;

   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

   // The line only pulls from the queue while idle, so a pop never overlaps a push into an empty queue.
   assign pop      = (state == IDLE) & ~empty;
   assign push_req = bus.MemWrite & hit_data;
   assign push_ok  = push_req & (~full | pop);
   assign clr_ovf  = bus.MemWrite & hit_stat & bus.WriteData[3];
   assign bit_done = (baud_cnt == BAUD_LAST);

   assign bus.ReadData = (bus.MemRead & hit_stat) ? {28'b0, overflow, TxBusy, full, empty} : 32'b0;

   // Only the low byte (and bit 3 for STATUS) of store data carries meaning.
   assign unused_wdata = ^bus.WriteData[31:8];

   // Queue storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push_ok) fifo_mem[wr_ptr] <= bus.WriteData[7:0];
   end

   // Queue pointers, occupancy and the sticky overflow flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push_req & full & ~pop) overflow <= 1'b1;
         else if (clr_ovf)           overflow <= 1'b0;
      end
   end

   // Frame state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state: each of START/DATA bits/STOP lasts one full baud period.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (!empty) state_nxt = START;
         START: if (bit_done) state_nxt = DATA;
         DATA:  if (bit_done && bit_idx == 3'd7) state_nxt = STOP;
         STOP:  if (bit_done) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Line level and busy flag decoded from the frame state.
   always_comb begin
      Tx     = 1'b1;
      TxBusy = 1'b1;
      case (state)
         IDLE:  TxBusy = 1'b0;
         START: Tx     = 1'b0;
         DATA:  Tx     = shift[0];
         STOP:  Tx     = 1'b1;
         default: begin
            Tx     = 1'b1;
            TxBusy = 1'b0;
         end
      endcase
   end

   // Baud counter, bit index and the shift register holding the byte on the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift    <= '0;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  shift    <= fifo_mem[rd_ptr];
                  baud_cnt <= '0;
               end
            end
            START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  shift    <= shift >> 1;
                  bit_idx  <= bit_idx + 1'b1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            STOP: begin
               if (bit_done) baud_cnt <= '0;
               else          baud_cnt <= baud_cnt + 1'b1;
            end
            default: baud_cnt <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
module tb_mmio_uart_tx;
   localparam logic [31:0] BASE  = 32'h1001_0000;
   localparam logic [31:0] STAT  = BASE + 32'd4;
   localparam int          N     = 4;
   localparam int          DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic Tx, TxBusy;

   mmio_uart_tx_if bus();

   mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .bus(bus), .Tx(Tx), .TxBusy(TxBusy)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model: queue of bytes plus a frame clock ----------------
   logic [7:0] m_q[$];
   logic [7:0] m_done[$];
   logic [7:0] m_cur = 8'h00;
   bit         m_ovf = 1'b0;
   bit         m_busy = 1'b0;
   int         m_cyc = 0;
   bit         m_pop, m_push, m_clr;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_ovf  = 1'b0;
         m_busy = 1'b0;
         m_cyc  = 0;
      end else begin
         m_pop  = !m_busy && (m_q.size() > 0);
         m_push = bus.MemWrite && (bus.Address == BASE);
         m_clr  = bus.MemWrite && (bus.Address == STAT) && bus.WriteData[3];
         if (m_busy) begin
            m_cyc++;
            if (m_cyc == 10*N) begin
               m_busy = 1'b0;
               m_done.push_back(m_cur);
            end
         end
         if (m_pop) begin
            m_cur  = m_q.pop_front();
            m_busy = 1'b1;
            m_cyc  = 0;
         end
         if (m_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(bus.WriteData[7:0]);
            else m_ovf = 1'b1;
         end
         if (m_clr) m_ovf = 1'b0;
      end
   end

   function automatic logic exp_tx();
      if (!m_busy) return 1'b1;
      if (m_cyc < N) return 1'b0;
      if (m_cyc < 9*N) return m_cur[3'((m_cyc - N) / N)];
      return 1'b1;
   endfunction

   function automatic logic [31:0] exp_status();
      return {28'b0, m_ovf, m_busy, m_q.size() == DEPTH, m_q.size() == 0};
   endfunction

   function automatic logic [31:0] exp_rdata();
      return (bus.MemRead && bus.Address == STAT) ? exp_status() : 32'h0;
   endfunction

   // compare process: every falling edge, all outputs against the model
   always @(negedge clk) begin
      chk("tx",    {31'b0, Tx},       {31'b0, exp_tx()});
      chk("busy",  {31'b0, TxBusy},   {31'b0, m_busy});
      chk("hit",   {31'b0, bus.Hit},  {31'b0, (bus.Address == BASE) || (bus.Address == STAT)});
      chk("rdata", bus.ReadData,      exp_rdata());
   end

   // independent serial receiver sampling the line mid-bit
   logic [7:0] rx_q[$];
   logic [7:0] rx_sh = 8'h00;
   bit         rx_act = 1'b0;
   int         rx_cyc = 0;

   always @(negedge clk) begin
      if (reset) rx_act = 1'b0;
      else if (!rx_act) begin
         if (Tx === 1'b0) begin
            rx_act = 1'b1;
            rx_cyc = 0;
         end
      end else begin
         rx_cyc++;
         if (rx_cyc >= N + N/2 && rx_cyc < 9*N && ((rx_cyc - N - N/2) % N) == 0)
            rx_sh[3'((rx_cyc - N) / N)] = Tx;
         if (rx_cyc == 9*N + N/2) rx_q.push_back(rx_sh);
         if (rx_cyc == 10*N - 1) rx_act = 1'b0;
      end
   end

   // ---------------- stimulus helpers (drive 1ns after the rising edge) ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      bus.Address   = 32'h0;
      bus.WriteData = 32'h0;
      bus.MemWrite  = 1'b0;
      bus.MemRead   = 1'b0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.Address = a; bus.WriteData = d; bus.MemWrite = 1'b1; bus.MemRead = 1'b0;
      tick();
      idle_bus();
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      bus.Address = a; bus.MemRead = 1'b1; bus.MemWrite = 1'b0;
      #1;
      d = bus.ReadData;
      tick();
      idle_bus();
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      int n = 0;
      @(negedge clk);
      while (TxBusy !== lvl && n < 2000) begin
         @(negedge clk);
         n++;
      end
      if (TxBusy !== lvl) chk(name, {31'b0, TxBusy}, {31'b0, lvl});
   endtask

   task automatic run_len(input logic lvl, output int n);
      n = 0;
      while (TxBusy === lvl && n < 2000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic drain();
      int n = 0;
      while ((TxBusy !== 1'b0 || m_q.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) chk("drain_timeout", {31'b0, TxBusy}, 32'h0);
      tick();
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

   logic [31:0] rdv;
   int          n1, n2, n3, base;
   logic [7:0]  exp4 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
   logic [7:0]  exp5 [6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};

   initial begin
      idle_bus();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // reset / idle
      chk("rst_tx",   {31'b0, Tx},     32'h1);
      chk("rst_busy", {31'b0, TxBusy}, 32'h0);
      rd(STAT, rdv);  chk("rst_status", rdv, 32'h1);
      rd(BASE, rdv);  chk("txdata_read", rdv, 32'h0);
      bus.Address = BASE + 32'd8; #1; chk("hit_base8", {31'b0, bus.Hit}, 32'h0);
      bus.Address = BASE + 32'd2; #1; chk("hit_unaligned", {31'b0, bus.Hit}, 32'h0);
      bus.Address = BASE;         #1; chk("hit_base", {31'b0, bus.Hit}, 32'h1);
      idle_bus();
      tick();

      // single frame 0x55 (upper store bits ignored)
      wr(BASE, 32'hFFFF_FF55);
      @(negedge clk); chk("tx_before_pop", {31'b0, Tx}, 32'h1);
      @(negedge clk); chk("tx_start_bit", {31'b0, Tx}, 32'h0);
      run_len(1'b1, n1);
      chk("frame_len_55", 32'(n1), 32'd40);
      chk("rx_55", {24'b0, rx_q[$]}, 32'h55);
      tick();

      // back-to-back frames
      wr(BASE, 32'hA1);
      wr(BASE, 32'hB2);
      wait_busy(1'b1, "busy_a1");
      run_len(1'b1, n1); run_len(1'b0, n2); run_len(1'b1, n3);
      chk("frame1_len", 32'(n1), 32'd40);
      chk("gap_len",    32'(n2), 32'd1);
      chk("frame2_len", 32'(n3), 32'd40);
      chk("rx_a1", {24'b0, rx_q[rx_q.size()-2]}, 32'hA1);
      chk("rx_b2", {24'b0, rx_q[$]}, 32'hB2);
      tick();

      // overflow while busy, then clear
      base = rx_q.size();
      wr(BASE, 32'h11);
      wait_busy(1'b1, "busy_ovf");
      tick();
      wr(BASE, 32'h22); wr(BASE, 32'h33); wr(BASE, 32'h44); wr(BASE, 32'h55);
      rd(STAT, rdv); chk("status_full", rdv, 32'h6);
      wr(BASE, 32'h66);
      rd(STAT, rdv); chk("status_ovf", rdv, 32'hE);
      wr(STAT, 32'h8);
      rd(STAT, rdv); chk("status_ovf_clr", rdv, 32'h6);
      drain();
      chk("ovf_frames", 32'(rx_q.size() - base), 32'd5);
      for (int i = 0; i < 5; i++) chk("ovf_order", {24'b0, rx_q[base+i]}, {24'b0, exp4[i]});

      // push on the idle pop edge while full
      base = rx_q.size();
      wr(BASE, 32'h01);
      wait_busy(1'b1, "busy_popedge");
      tick();
      wr(BASE, 32'h02); wr(BASE, 32'h03); wr(BASE, 32'h04); wr(BASE, 32'h05);
      wait_busy(1'b0, "idle_popedge");
      #1;
      bus.Address = BASE; bus.WriteData = 32'h06; bus.MemWrite = 1'b1;
      tick();
      idle_bus();
      rd(STAT, rdv); chk("status_popedge", rdv, 32'h6);
      drain();
      chk("popedge_frames", 32'(rx_q.size() - base), 32'd6);
      for (int i = 0; i < 6; i++) chk("popedge_order", {24'b0, rx_q[base+i]}, {24'b0, exp5[i]});

      // reset in the middle of DATA
      wr(BASE, 32'h00); wr(BASE, 32'h77); wr(BASE, 32'h78);
      wait_busy(1'b1, "busy_rst");
      repeat (3*N) @(negedge clk);
      chk("tx_in_data", {31'b0, Tx}, 32'h0);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_tx",   {31'b0, Tx},     32'h1);
      chk("async_rst_busy", {31'b0, TxBusy}, 32'h0);
      bus.Address = STAT; bus.MemRead = 1'b1; #1;
      chk("async_rst_status", bus.ReadData, 32'h1);
      idle_bus();
      repeat (2) tick();
      reset = 1'b0;
      base = rx_q.size();
      repeat (100) tick();
      chk("no_frames_after_rst", 32'(rx_q.size() - base), 32'd0);
      chk("idle_after_rst", {31'b0, TxBusy}, 32'h0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 9))
            0, 1, 2, 3: bus.Address = BASE;
            4, 5:       bus.Address = STAT;
            6:          bus.Address = BASE + 32'd8;
            7:          bus.Address = BASE + 32'($urandom_range(1, 3));
            8:          bus.Address = BASE - 32'd4;
            default:    bus.Address = $urandom;
         endcase
         bus.WriteData = $urandom;
         bus.MemWrite  = ($urandom_range(0, 3) == 0);
         bus.MemRead   = ($urandom_range(0, 1) == 0);
         tick();
      end
      idle_bus();
      drain();

      chk("rx_count_vs_model", 32'(rx_q.size()), 32'(m_done.size()));
      for (int i = 0; i < rx_q.size() && i < m_done.size(); i++)
         chk("rx_byte_vs_model", {24'b0, rx_q[i]}, {24'b0, m_done[i]});

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
